// File: rtl/compute_pkg.sv
// rtl/compute_pkg.sv - shared types for the compute dispatcher
package compute_pkg;

    localparam int ADDR_WIDTH = 13;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr_a;
        logic [ADDR_WIDTH-1:0] addr_b;
        logic [ADDR_WIDTH-1:0] addr_out;
        logic [31:0]           len;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE
    } disp_state_t;

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - synchronous command FIFO with wrap-bit pointers
module cmd_fifo
    import compute_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  cmd_t                     push_data,
    input  logic                     pop,
    output cmd_t                     head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);

    cmd_t           mem [DEPTH];
    logic [PW:0]    wr_ptr;
    logic [PW:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PW-1:0]] <= push_data;
    end

    assign head  = mem[rd_ptr[PW-1:0]];
    assign level = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (level == (PW+1)'(DEPTH));

endmodule

// File: rtl/compute_dispatch.sv
// rtl/compute_dispatch.sv - queues vector-add commands and issues them to the engine
module compute_dispatch
    import compute_pkg::*;
#(
    parameter int ADDR_WIDTH = compute_pkg::ADDR_WIDTH,
    parameter int DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [ADDR_WIDTH-1:0]    cmd_addr_a,
    input  logic [ADDR_WIDTH-1:0]    cmd_addr_b,
    input  logic [ADDR_WIDTH-1:0]    cmd_addr_out,
    input  logic [31:0]              cmd_len,
    output logic                     start,
    output logic [ADDR_WIDTH-1:0]    addr_a,
    output logic [ADDR_WIDTH-1:0]    addr_b,
    output logic [ADDR_WIDTH-1:0]    addr_out,
    output logic [31:0]              len,
    input  logic                     done,
    output logic                     cmp_valid,
    output logic                     cmp_err,
    output logic [15:0]              done_count,
    output logic [15:0]              err_count,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     busy
);

    localparam logic [32:0] LIMIT = 33'(1) << ADDR_WIDTH;

    disp_state_t state, state_next;
    cmd_t        head;
    logic        full, empty, push, pop, head_ok, load;
    logic        start_next, cmp_valid_next, cmp_err_next, done_inc, err_inc;

    assign push      = cmd_valid && !full;
    assign cmd_ready = !full;
    assign busy      = (state != IDLE) || !empty;

    cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({cmd_addr_a, cmd_addr_b, cmd_addr_out, cmd_len}),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level)
    );

    // Zero length or any window running past the top of BRAM is unsafe for the engine.
    always_comb begin
        head_ok = (head.len != 32'd0)
               && (33'(head.addr_a)   + 33'(head.len) <= LIMIT)
               && (33'(head.addr_b)   + 33'(head.len) <= LIMIT)
               && (33'(head.addr_out) + 33'(head.len) <= LIMIT);
    end

    always_comb begin
        state_next     = state;
        pop            = 1'b0;
        load           = 1'b0;
        start_next     = 1'b0;
        cmp_valid_next = 1'b0;
        cmp_err_next   = 1'b0;
        done_inc       = 1'b0;
        err_inc        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (head_ok) begin
                        load       = 1'b1;
                        state_next = ISSUE;
                    end else begin
                        cmp_valid_next = 1'b1;
                        cmp_err_next   = 1'b1;
                        err_inc        = 1'b1;
                    end
                end
            end
            ISSUE: begin
                start_next = 1'b1;
                state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (done) begin
                    cmp_valid_next = 1'b1;
                    done_inc       = 1'b1;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            start      <= 1'b0;
            cmp_valid  <= 1'b0;
            cmp_err    <= 1'b0;
            addr_a     <= '0;
            addr_b     <= '0;
            addr_out   <= '0;
            len        <= '0;
            done_count <= '0;
            err_count  <= '0;
        end else begin
            state     <= state_next;
            start     <= start_next;
            cmp_valid <= cmp_valid_next;
            cmp_err   <= cmp_err_next;
            if (load) begin
                addr_a   <= head.addr_a;
                addr_b   <= head.addr_b;
                addr_out <= head.addr_out;
                len      <= head.len;
            end
            if (done_inc) done_count <= done_count + 16'd1;
            if (err_inc)  err_count  <= err_count + 16'd1;
        end
    end

endmodule
